// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_RSP = 2'd1,
    ST_DBG_RSP = 2'd2
  } arb_state_e;

  localparam int DBG_MAX_WAIT_DEF = 4;
  localparam int WAIT_W           = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, debug and memory-command signal bundle of the arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_stall_o;

  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              dbg_gnt_o;
  logic              dbg_rvalid_o;
  logic [DATA_W-1:0] dbg_rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug arbiter in front of a 1-cycle-latency data memory
// Optional: DMEM_ARB_DBG_WRITE_EN lets debug writes reach the memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEF
) (
  input logic             clk_i,
  input logic             rst_i,
  dmem_arbiter_if.slave   bus
);

  localparam logic [WAIT_W-1:0] MAX_WAIT = WAIT_W'(DBG_MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic              in_idle;
  logic              issue_dbg;
  logic              issue_cpu;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  // Arbitration; gating with rst_i keeps every command output quiet during reset
  always_comb begin
    in_idle   = rst_i && (state_q == ST_IDLE);
    issue_dbg = in_idle && bus.dbg_req_i &&
                ((wait_q == MAX_WAIT) || !bus.cpu_req_i);
    issue_cpu = in_idle && bus.cpu_req_i && !issue_dbg;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_dbg && !bus.dbg_we_i)      state_d = ST_DBG_RSP;
        else if (issue_cpu && !bus.cpu_we_i) state_d = ST_CPU_RSP;
      end
      ST_CPU_RSP: begin
        state_d     = ST_IDLE;
        cpu_rdata_d = bus.mem_rdata_i;
      end
      ST_DBG_RSP: begin
        state_d     = ST_IDLE;
        dbg_rdata_d = bus.mem_rdata_i;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!bus.dbg_req_i || issue_dbg) wait_d = '0;
    else if (wait_q < MAX_WAIT)      wait_d = wait_q + 1'b1;
  end

  always_comb begin
    bus.mem_en_o     = 1'b0;
    bus.mem_we_o     = 1'b0;
    issue_addr       = '0;
    issue_wdata      = '0;
    bus.cpu_stall_o  = 1'b0;
    bus.dbg_gnt_o    = 1'b0;
    bus.dbg_rvalid_o = rst_i && (state_q == ST_DBG_RSP);
    // Response data is visible in its own cycle, then held by the _q copy
    bus.cpu_rdata_o  = cpu_rdata_d;
    bus.dbg_rdata_o  = dbg_rdata_d;
    if (issue_dbg) begin
      bus.dbg_gnt_o   = 1'b1;
      bus.cpu_stall_o = bus.cpu_req_i;
      if (!bus.dbg_we_i) begin
        bus.mem_en_o = 1'b1;
        issue_addr   = bus.dbg_addr_i;
        issue_wdata  = bus.dbg_wdata_i;
      end else begin
`ifdef DMEM_ARB_DBG_WRITE_EN
        bus.mem_en_o = 1'b1;
        bus.mem_we_o = 1'b1;
        issue_addr   = bus.dbg_addr_i;
        issue_wdata  = bus.dbg_wdata_i;
`else
        bus.mem_en_o = 1'b0;
`endif
      end
    end else if (issue_cpu) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_we_o    = bus.cpu_we_i;
      issue_addr      = bus.cpu_addr_i;
      issue_wdata     = bus.cpu_wdata_i;
      bus.cpu_stall_o = !bus.cpu_we_i;
    end
    bus.mem_addr_o  = issue_addr;
    bus.mem_wdata_o = issue_wdata;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, data-memory byte address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter DBG_MAX_WAIT, default 4, maximum consecutive denied debug cycles before debug gets forced priority; legal range 1..15.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 cpu_req_i  in  1  pipeline MEM-stage access request (MemRead|MemWrite).
REQ-007 cpu_we_i  in  1  1 = write, 0 = read.
REQ-008 cpu_addr_i / cpu_wdata_i  in  ADDR_W / DATA_W  CPU address and write data.
REQ-009 cpu_rdata_o  out  DATA_W  CPU read data; valid in the cycle cpu_stall_o falls after a read.
REQ-010 cpu_stall_o  out  1  freeze PC and IF/ID, ID/EX, EX/MEM latches.
REQ-011 dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i  in  1/1/ADDR_W/DATA_W  debug/dump port request, held until dbg_gnt_o.
REQ-012 dbg_gnt_o  out  1  one-cycle pulse: debug access issued this cycle.
REQ-013 dbg_rvalid_o / dbg_rdata_o  out  1 / DATA_W  one-cycle pulse with read data.
REQ-014 mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o  out  1/1/ADDR_W/DATA_W  memory command; mem_rdata_i  in  DATA_W  read data, one-cycle latency.

Function
REQ-015 FSM states IDLE, CPU_RSP, DBG_RSP; an access can be issued only in IDLE; at most one issue per cycle.
REQ-016 Arbitration in IDLE: if dbg_req_i and wait count == DBG_MAX_WAIT, issue debug; else if cpu_req_i, issue CPU; else if dbg_req_i, issue debug.
REQ-017 Issue drives mem_en_o=1 and the winner's we/addr/wdata combinationally in the same cycle; all mem_* outputs 0 when nothing is issued.
REQ-018 CPU write issue: cpu_stall_o=0 that cycle, FSM stays IDLE.
REQ-019 CPU read issue: cpu_stall_o=1, FSM -> CPU_RSP; in CPU_RSP cpu_rdata_o=mem_rdata_i, cpu_stall_o=0, FSM -> IDLE.
REQ-020 cpu_stall_o=1 in any IDLE cycle where cpu_req_i=1 and debug wins.
REQ-021 Debug issue: dbg_gnt_o=1; a read moves FSM -> DBG_RSP, where dbg_rvalid_o=1 and dbg_rdata_o=mem_rdata_i, then -> IDLE; a write stays IDLE.
REQ-022 In CPU_RSP/DBG_RSP no issue occurs; pending requests wait and cpu_stall_o follows REQ-019/020 only.
REQ-023 Wait counter (4 bits) increments each cycle dbg_req_i=1 and dbg_gnt_o=0, saturating at DBG_MAX_WAIT; clears on dbg_gnt_o or dbg_req_i=0.
REQ-024 cpu_rdata_o and dbg_rdata_o hold their last value outside their valid cycles.

Reset
REQ-025 rst_i low: FSM=IDLE, wait counter=0, cpu_rdata_o=0, dbg_rdata_o=0; all pulse/command outputs 0 while low.
REQ-026 Reset during CPU_RSP/DBG_RSP discards the response; no rvalid after release.

Configuration
REQ-027 Macro DMEM_ARB_DBG_WRITE_EN defined: debug writes drive mem_we_o=1.
REQ-028 Macro undefined: debug writes are granted (dbg_gnt_o pulse) but mem_en_o=mem_we_o=0 that cycle; memory untouched.

Structure
REQ-029 Package dmem_arb_pkg holds the FSM state enum and default DBG_MAX_WAIT.
REQ-030 No sub-module; single flat block instantiated between Pipe_CPU_1 MEM stage and the data memory.

Verification
REQ-031 CPU read addr 0x10, memory word 7 -> stall high 1 cycle, next cycle cpu_rdata_o=7, stall low.
REQ-032 CPU write 0x8 data 5, no debug -> mem_we_o=1 same cycle, stall never asserted.
REQ-033 CPU requests every cycle, debug read held continuously -> debug granted on 5th cycle (DBG_MAX_WAIT=4), CPU stalled exactly that cycle.
REQ-034 Simultaneous first-cycle CPU and debug requests, count 0 -> CPU wins; dbg_gnt_o stays 0.
REQ-035 Debug write 0x4 data 9, macro undefined -> dbg_gnt_o pulse, mem_we_o=0, later read 0x4 returns old value.
REQ-036 rst_i low in CPU_RSP -> no cpu_rdata_o update, outputs 0, FSM IDLE after release.
